// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - MIPS HI/LO register unit: multiply, optional iterative divide, MT* commit and MF* forwarding
// Optional divider datapath and DIV/DONE states are compiled in when HILO_DIV_EN is defined.
module hilo_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              op_ready,
    output logic              busy,
    input  logic              flush,
    input  logic              wr_hi_me,
    input  logic              wr_lo_me,
    input  logic [DATA_W-1:0] wdata_me,
    input  logic              wr_hi_wb,
    input  logic              wr_lo_wb,
    input  logic [DATA_W-1:0] wdata_wb,
    input  logic              rd_sel_ex,
    output logic [DATA_W-1:0] rd_data_ex,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, hi_d, lo_d;
    logic                sgn_q, sgn_d;
    logic                unit_wr;
    logic [DATA_W-1:0]   unit_hi, unit_lo;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic                accept;

    assign op_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign accept   = op_valid && op_ready;

    // sgn_q selects signed handling; extension to 2*DATA_W makes one multiplier serve both
    assign ext_a = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign ext_b = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod  = ext_a * ext_b;

`ifdef HILO_DIV_EN
    localparam int CW = $clog2(DATA_W + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [DATA_W:0]   shifted, diff;
    logic              q_neg, r_neg;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
        return (s && x[DATA_W-1]) ? (~x + 1'b1) : x;
    endfunction

    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign q_neg   = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
    assign r_neg   = sgn_q & a_q[DATA_W-1];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        unit_wr = 1'b0;
        unit_hi = prod[2*DATA_W-1:DATA_W];
        unit_lo = prod[DATA_W-1:0];
`ifdef HILO_DIV_EN
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d   = src_a;
                    b_d   = src_b;
                    sgn_d = ~op[0];
                    if (!op[1]) begin
                        state_d = S_MUL;
                    end
`ifdef HILO_DIV_EN
                    else begin
                        state_d = S_DIV;
                        cnt_d   = CW'(DATA_W);
                        quo_d   = mag(src_a, ~op[0]);
                        dvs_d   = mag(src_b, ~op[0]);
                        rem_d   = '0;
                    end
`endif
                end
            end
            S_MUL: begin
                unit_wr = 1'b1;
                state_d = S_IDLE;
            end
`ifdef HILO_DIV_EN
            S_DIV: begin
                // Restoring step: quotient bits shift in from the right as dividend bits shift out
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                unit_wr = 1'b1;
                state_d = S_IDLE;
                if (b_q == '0) begin
                    unit_lo = '1;
                    unit_hi = a_q;
                end else begin
                    unit_lo = q_neg ? (~quo_q + 1'b1) : quo_q;
                    unit_hi = r_neg ? (~rem_q + 1'b1) : rem_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            unit_wr = 1'b0;
        end
    end

    // WB commit outranks a unit result landing on the same half in the same cycle
    assign hi_d = wr_hi_wb ? wdata_wb : (unit_wr ? unit_hi : hi_q);
    assign lo_d = wr_lo_wb ? wdata_wb : (unit_wr ? unit_lo : lo_q);

    always_comb begin
        rd_data_ex = lo_q;
        if (rd_sel_ex) begin
            if (wr_hi_me)      rd_data_ex = wdata_me;
            else if (wr_hi_wb) rd_data_ex = wdata_wb;
            else               rd_data_ex = hi_q;
        end else begin
            if (wr_lo_me)      rd_data_ex = wdata_me;
            else if (wr_lo_wb) rd_data_ex = wdata_wb;
            else               rd_data_ex = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef HILO_DIV_EN
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef HILO_DIV_EN
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
`endif
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit with an arithmetic reference model
module tb_hilo_unit;
    logic        clk = 1'b0;
    logic        rst_n, op_valid, op_ready, busy, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata_me, wdata_wb, rd_data_ex, hi_q, lo_q;
    logic        wr_hi_me, wr_lo_me, wr_hi_wb, wr_lo_wb, rd_sel_ex;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = 32'h0, exp_lo = 32'h0;

    always #5 clk = ~clk;

    hilo_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .op_ready(op_ready), .busy(busy),
        .flush(flush), .wr_hi_me(wr_hi_me), .wr_lo_me(wr_lo_me), .wdata_me(wdata_me),
        .wr_hi_wb(wr_hi_wb), .wr_lo_wb(wr_lo_wb), .wdata_wb(wdata_wb),
        .rd_sel_ex(rd_sel_ex), .rd_data_ex(rd_data_ex), .hi_q(hi_q), .lo_q(lo_q)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural effect of one operation, from MIPS arithmetic rules
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p, sa, sb;
        if (!o[1]) begin
            if (o == 2'd0) p = longint'($signed(a)) * longint'($signed(b));
            else           p = longint'({32'h0, a}) * longint'({32'h0, b});
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else begin
`ifdef HILO_DIV_EN
            if (b == 32'h0) begin
                exp_lo = 32'hFFFF_FFFF;
                exp_hi = a;
            end else begin
                if (o == 2'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'h0, a});
                    sb = longint'({32'h0, b});
                end
                p      = sa / sb;
                exp_lo = p[31:0];
                p      = sa % sb;
                exp_hi = p[31:0];
            end
`endif
        end
    endtask

    function automatic int busy_len(input logic [1:0] o);
`ifdef HILO_DIV_EN
        return o[1] ? 33 : 1;
`else
        return o[1] ? 0 : 1;
`endif
    endfunction

    // Leaves the bench in the first cycle after the accept edge
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        chk("ready_before_op", {31'h0, op_ready}, 32'h1);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        step();
        op_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        start_op(o, a, b);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk({tag, "_busy_cycles"}, n, busy_len(o));
        model(o, a, b);
        chk({tag, "_hi"}, hi_q, exp_hi);
        chk({tag, "_lo"}, lo_q, exp_lo);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b, e;
        logic        hm, lm, hw, lw;

        rst_n = 1'b0; op_valid = 1'b0; op = 2'd0; src_a = 32'h0; src_b = 32'h0;
        flush = 1'b0; wr_hi_me = 1'b0; wr_lo_me = 1'b0; wdata_me = 32'h0;
        wr_hi_wb = 1'b0; wr_lo_wb = 1'b0; wdata_wb = 32'h0; rd_sel_ex = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_hi", hi_q, 32'h0);
        chk("reset_lo", lo_q, 32'h0);
        chk("reset_ready", {31'h0, op_ready}, 32'h1);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        run_op("mult_neg1x2", 2'd0, 32'hFFFF_FFFF, 32'h2);
        chk("mult_neg1x2_const_hi", hi_q, 32'hFFFF_FFFF);
        chk("mult_neg1x2_const_lo", lo_q, 32'hFFFF_FFFE);
        run_op("multu_ffx2", 2'd1, 32'hFFFF_FFFF, 32'h2);
        chk("multu_ffx2_const_hi", hi_q, 32'h0000_0001);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'h2);
        run_op("divu_7_0", 2'd3, 32'h7, 32'h0);
        run_op("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_by0", 2'd2, 32'h8000_0005, 32'h0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 6 == 5) ? 32'h0 : $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(0, 31);
            run_op("rand_op", o, a, b);
        end

        rd_sel_ex = 1'b0;
        wr_lo_me = 1'b1; wdata_me = 32'h11;
        wr_lo_wb = 1'b1; wdata_wb = 32'h22;
        #1 chk("fwd_me_over_wb", rd_data_ex, 32'h11);
        wr_lo_me = 1'b0;
        #1 chk("fwd_wb_only", rd_data_ex, 32'h22);
        step();
        wr_lo_wb = 1'b0;
        exp_lo = 32'h22;
        chk("wb_commit_lo", lo_q, exp_lo);
        chk("wb_commit_hi_kept", hi_q, exp_hi);

        for (int i = 0; i < 12; i++) begin
            hm = 1'($urandom); lm = 1'($urandom); hw = 1'($urandom); lw = 1'($urandom);
            wr_hi_me = hm; wr_lo_me = lm; wr_hi_wb = hw; wr_lo_wb = lw;
            wdata_me = $urandom; wdata_wb = $urandom;
            rd_sel_ex = 1'b1;
            #1 chk("fwd_rand_hi", rd_data_ex, hm ? wdata_me : (hw ? wdata_wb : exp_hi));
            rd_sel_ex = 1'b0;
            #1 chk("fwd_rand_lo", rd_data_ex, lm ? wdata_me : (lw ? wdata_wb : exp_lo));
            if (hw) exp_hi = wdata_wb;
            if (lw) exp_lo = wdata_wb;
            step();
            wr_hi_me = 1'b0; wr_lo_me = 1'b0; wr_hi_wb = 1'b0; wr_lo_wb = 1'b0;
            chk("commit_rand_hi", hi_q, exp_hi);
            chk("commit_rand_lo", lo_q, exp_lo);
        end

        a = 32'h1234_5678; b = 32'h0000_0100;
        start_op(2'd0, a, b);
        wr_hi_wb = 1'b1; wdata_wb = 32'hAA;
        step();
        wr_hi_wb = 1'b0;
        model(2'd0, a, b);
        chk("collide_hi_wb_wins", hi_q, 32'hAA);
        chk("collide_lo_product", lo_q, exp_lo);
        exp_hi = 32'hAA;

        start_op(2'd0, 32'h7, 32'h9);
        flush = 1'b1;
        wr_lo_wb = 1'b1; wdata_wb = 32'h5A5A;
        step();
        flush = 1'b0; wr_lo_wb = 1'b0;
        exp_lo = 32'h5A5A;
        chk("flush_mul_busy", {31'h0, busy}, 32'h0);
        chk("flush_mul_hi", hi_q, exp_hi);
        chk("flush_mul_lo_wb", lo_q, exp_lo);

`ifdef HILO_DIV_EN
        start_op(2'd3, 32'd1000, 32'd3);
        repeat (9) step();
        chk("flush_div_busy_before", {31'h0, busy}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_div_busy", {31'h0, busy}, 32'h0);
        chk("flush_div_ready", {31'h0, op_ready}, 32'h1);
        chk("flush_div_hi", hi_q, exp_hi);
        chk("flush_div_lo", lo_q, exp_lo);
        start_op(2'd2, 32'd1000, 32'd3);
        repeat (4) step();
`else
        start_op(2'd2, 32'd1000, 32'd3);
        chk("nodiv_busy", {31'h0, busy}, 32'h0);
        chk("nodiv_ready", {31'h0, op_ready}, 32'h1);
        step();
        chk("nodiv_hi", hi_q, exp_hi);
        chk("nodiv_lo", lo_q, exp_lo);
        start_op(2'd1, 32'd1000, 32'd3);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        chk("midop_reset_hi", hi_q, exp_hi);
        chk("midop_reset_lo", lo_q, exp_lo);
        chk("midop_reset_ready", {31'h0, op_ready}, 32'h1);
        step();
        chk("midop_reset_hi_later", hi_q, exp_hi);
        chk("midop_reset_busy_later", {31'h0, busy}, 32'h0);

        e = 32'hFFFF_FFFF;
        run_op("post_reset_multu", 2'd1, e, e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
